// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional overflow output is enabled with `SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } sa_state_e;

   localparam int SA_DEFAULT_WIDTH = 8;

   function automatic int sa_cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder used by serial_adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = sa_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sa_state_e        state_q;
   sa_state_e        state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             shift_en;
   logic             accept;
   logic             fa_s;
   logic             fa_c;

   assign shift_en = (state_q == SHIFT);
   assign accept   = start && !shift_en;

   fa_cell u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operands drain LSB first; the result fills from the MSB side.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         cnt_q   <= '0;
      end else if (shift_en) begin
         a_q     <= {1'b0, a_q[WIDTH-1:1]};
         b_q     <= {1'b0, b_q[WIDTH-1:1]};
         sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
         carry_q <= fa_c;
         cnt_q   <= cnt_q + CW'(1);
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic last;
   logic ovf_q;

   assign last = shift_en && (cnt_q == LAST);

   // On the MSB step the carry flop holds the carry into the sign bit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= carry_q ^ fa_c;
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy = shift_en;
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = carry_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that computes `a + b + cin` one bit per clock, LSB first, using a single one-bit full-adder cell plus a carry flip-flop. It accepts two WIDTH-bit operands on a start pulse. Results are produced after WIDTH shift cycles, so it trades latency for area compared with a ripple-carry array of full adders. It sits directly downstream of the full-adder cell: it instantiates that cell and consumes the cell's sum and carry-out every cycle.

## Interface
- `WIDTH`, default 8 — operand and sum width in bits; legal range 2..32.
- `clock` input, 1 bit — the single clock; all state changes on its rising edge.
- `resetn` input, 1 bit — asynchronous, active-low reset.
- `start` input, 1 bit — request to begin an addition; sampled on each rising edge.
- `a` input, WIDTH bits — operand A; captured when `start` is accepted.
- `b` input, WIDTH bits — operand B; captured when `start` is accepted.
- `cin` input, 1 bit — carry-in; captured when `start` is accepted.
- `busy` output, 1 bit — high while the shift phase is in progress.
- `done` output, 1 bit — one-cycle pulse marking that `sum`/`cout` are valid.
- `sum` output, WIDTH bits — result register.
- `cout` output, 1 bit — final carry-out.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - SHIFT: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Accepting a start: `start` is accepted when `busy`=0, i.e. in IDLE or DONE. On acceptance:
  - shift registers A and B are loaded from `a` and `b`;
  - the carry flop is loaded from `cin`;
  - the bit counter is cleared to 0;
  - the state moves to SHIFT.
- Each SHIFT cycle:
  - The cell takes A[0], B[0] and the carry flop; outputs are s and c.
  - A and B shift right by one; a zero enters at the MSB.
  - The sum register shifts right by one, with s entering at bit WIDTH-1.
  - The carry flop takes c.
  - The counter increments.
- When the counter reaches WIDTH-1 during a SHIFT cycle, that cycle is the last shift and the next state is DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless a new start is accepted in that cycle.
- `cout` always reflects the carry flop. `sum` reflects the sum register.
  - Both are valid from the DONE cycle onward.
  - Both hold their values until the next accepted start.
  - During SHIFT their contents are partial and undefined for the consumer.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- Arithmetic: the result is an unsigned (WIDTH+1)-bit value {cout, sum} = a + b + cin. There is no saturation.

## Timing
- Reset values (asynchronous, immediate on `resetn`=0):
  - state = IDLE;
  - `busy`=0, `done`=0;
  - `sum`=0, `cout`=0;
  - counter = 0, A = 0, B = 0.
- Reset mid-operation aborts the operation with no `done` pulse. The first start is accepted on the first edge after `resetn` rises.
- Latency: start accepted at edge 0 → `busy` high for cycles 1..WIDTH → `done` high in cycle WIDTH+1.
- Back-to-back operation: a start asserted during the DONE cycle is accepted. `busy` rises on the next edge, so the throughput is one result per WIDTH+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_ADDER_OVF_EN`.
- When defined, adds output port `ovf` (1 bit), the signed two's-complement overflow flag:
  - it equals the carry into bit WIDTH-1 XOR the final carry-out;
  - it is latched on the last SHIFT cycle;
  - it is valid and held under the same rules as `cout`;
  - its reset value is 0.
- When undefined, the `ovf` port and its flop do not exist. All other behaviour is identical.

## Structure
- Package `serial_adder_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default-width constant `SA_DEFAULT_WIDTH` = 8;
  - the counter-width function, clog2(WIDTH).
- One sub-module, `fa_cell`: a purely combinational one-bit full adder with s = a^b^cin and cout = majority(a,b,cin). It is instantiated exactly once.

## Test plan
All scenarios use WIDTH=8.
- 8'h3C + 8'h5A, cin=0, start at edge 0 → `busy` high in cycles 1–8, `done` pulse in cycle 9, `sum`=8'h96, `cout`=0.
- 8'hFF + 8'h01, cin=0 → `sum`=8'h00, `cout`=1; `ovf`=0 when `SERIAL_ADDER_OVF_EN` is defined.
- 8'h7F + 8'h00, cin=1 → `sum`=8'h80, `cout`=0, `ovf`=1. Also check 8'h00 + 8'h00, cin=0 → `sum`=0, `cout`=0, `ovf`=0.
- Start with 8'h01+8'h01, then re-assert `start` with 8'hAA+8'h55 in cycle 4 → the second request is ignored; the result is 8'h02, `cout`=0, with a single `done` pulse.
- Assert `start` in the DONE cycle of the first operation → the second operation begins on the next edge, and its `done` follows 9 cycles after the first `done`.
- Drive `resetn`=0 in cycle 5 of an operation → `busy`, `sum` and `cout` drop to 0 immediately and no `done` pulse occurs. A fresh start after release gives the correct result.
